lipsi_uart_loader: RTL and testbench
====================================

// Module: lipsi_uart_loader
// PURPOSE
//  Serial program loader that sits directly upstream of the Lipsi core.
//  Receives a framed program image over a UART pin (8N1, LSB first) and writes it byte-by-byte
//  into the core's instruction memory.
//  Holds the core in reset until a frame is received with a valid checksum, then releases it.
//  Frame: 0xA5 sync, length L (0 encodes 256), L data bytes, checksum C with (sum(data)+C) mod 256 == 0.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); must be >= 4
//  ADDR_W        8    instruction memory address width
//  SYNC_BYTE     8'hA5  frame start marker
// PORTS
//  clock         in   1       single system clock
//  reset         in   1       synchronous, active-high reset
//  rx_i          in   1       asynchronous UART receive line, idle high
//  mem_wr_en_o   out  1       one-cycle write strobe to instruction memory
//  mem_wr_addr_o out  ADDR_W  write address
//  mem_wr_data_o out  8       write data
//  core_hold_o   out  1       high = keep Lipsi core in reset
//  loaded_o      out  1       high = valid program loaded, core running
//  error_o       out  1       sticky: framing or checksum error in last frame
//  busy_o        out  1       high while a frame is in progress (sync byte seen, frame not finished)
// BEHAVIOUR
//  Reset (sync, high): all state to IDLE; mem_wr_en=0, addr=0, data=0, core_hold=1, loaded=0,
//   error=0, busy=0; synchronizer flops preset to 1 (idle line).
//  RX front end: 2-FF synchronizer on rx_i; all timing below is relative to the synchronized signal.
//   - Start: on falling edge, count CLKS_PER_BIT/2; if line still 0 accept start, else abort (glitch).
//   - Then sample 8 data bits, then the stop bit, each CLKS_PER_BIT apart (LSB first).
//   - Stop=1: rx_valid pulses one cycle after the stop sample. Stop=0: framing error, no rx_valid.
//  Frame FSM: IDLE -> LEN -> DATA -> CHK -> IDLE.
//   IDLE: non-sync bytes ignored. On SYNC_BYTE: busy=1, core_hold=1, loaded=0, error=0,
//    addr=0, sum=0 -> LEN.
//   LEN: remaining = (byte==0) ? 256 : byte -> DATA.
//   DATA: each byte: mem_wr_en=1 for exactly one cycle (the cycle after rx_valid), with
//    data=byte and addr=current. Then addr+1 (mod 2^ADDR_W), sum+=byte (mod 256), remaining-1.
//    After the last byte -> CHK.
//   CHK: if (sum+byte) mod 256 == 0: loaded=1, core_hold=0. Else error=1, core_hold stays 1.
//    Both take effect one cycle after rx_valid; busy=0 -> IDLE.
//  Framing error in LEN/DATA/CHK: error=1, busy=0, core_hold stays 1 -> IDLE.
//   Memory bytes already written are not rolled back.
//  Framing error in IDLE: byte is dropped, error unchanged.
//  SYNC_BYTE inside LEN/DATA/CHK is ordinary payload, never a resync.
//  New SYNC_BYTE while loaded=1 starts a reload: core_hold reasserts in the cycle after rx_valid.
//  Reset mid-frame: frame is abandoned, outputs return to reset values, core held.
//  At most one write per byte; mem_wr_en never high on two consecutive cycles.
//  addr holds its last value between writes.
// TESTING (bench uses CLKS_PER_BIT=8)
//  1. Reset, rx idle -> core_hold=1, loaded=0, error=0, mem_wr_en never asserted.
//  2. Send A5 03 11 22 33 9A -> writes (0,11),(1,22),(2,33) in order; then loaded=1,
//     core_hold=0 one cycle after checksum rx_valid.
//  3. Send A5 02 10 20 00 (bad checksum) -> 2 writes, then error=1, loaded=0, core_hold=1;
//     a following good frame clears error on its sync byte.
//  4. Send 5A 00 FF, then a valid frame -> the first three bytes are ignored and the frame loads normally.
//  5. Send A5 00 + 256 bytes (value = index) + 80 -> addr 0..FF written, loaded=1.
//  6. During a DATA byte, drive the stop bit 0 -> error=1, busy=0, core_hold=1.
//     Separately, assert reset mid-frame -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/lipsi_uart_loader_if.sv
`default_nettype none
// ============================================================================
// lipsi_uart_loader_if : UART pin plus instruction-memory write bus and
//                        core-control status of the Lipsi program loader
// Revision: 1.0
// ============================================================================
interface lipsi_uart_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_i;
  logic              mem_wr_en_o;
  logic [ADDR_W-1:0] mem_wr_addr_o;
  logic [7:0]        mem_wr_data_o;
  logic              core_hold_o;
  logic              loaded_o;
  logic              error_o;
  logic              busy_o;

  // master: the loader itself; slave: the environment (pin driver, memory, core)
  modport master (
    input  rx_i,
    output mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
    output core_hold_o, loaded_o, error_o, busy_o
  );
  modport slave (
    output rx_i,
    input  mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o,
    input  core_hold_o, loaded_o, error_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/lipsi_uart_loader.sv
`default_nettype none
// ============================================================================
// lipsi_uart_loader : 8N1 UART receiver plus frame parser that writes a
//                     checksummed program image into Lipsi instruction memory
// Revision: 1.0
// ============================================================================
module lipsi_uart_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ADDR_W       = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  lipsi_uart_loader_if.master bus
);
  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_LEN, F_DATA, F_CHK} frame_state_t;

  logic             sync1, sync2, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_valid, rx_ferr;

  frame_state_t      fstate;
  logic [8:0]        remaining;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] wr_ptr;
  logic              mem_wr_en, core_hold, loaded, error, busy;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;

  // Receiver: edge-triggered start so a line stuck low after a framing error
  // does not retrigger until it has returned high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      sync1    <= bus.rx_i;
      sync2    <= sync1;
      rx_prev  <= sync2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !sync2) begin
            rx_state <= RX_START;
            cnt      <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            rx_valid <= sync2;
            rx_ferr  <= !sync2;
            rx_state <= RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fstate      <= F_IDLE;
      remaining   <= '0;
      sum         <= '0;
      wr_ptr      <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      core_hold   <= 1'b1;
      loaded      <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (fstate != F_IDLE && rx_ferr) begin
        error  <= 1'b1;
        busy   <= 1'b0;
        fstate <= F_IDLE;
      end else if (rx_valid) begin
        case (fstate)
          F_IDLE: begin
            if (shift == SYNC_BYTE) begin
              busy        <= 1'b1;
              core_hold   <= 1'b1;
              loaded      <= 1'b0;
              error       <= 1'b0;
              mem_wr_addr <= '0;
              wr_ptr      <= '0;
              sum         <= '0;
              fstate      <= F_LEN;
            end
          end
          F_LEN: begin
            remaining <= (shift == 8'd0) ? 9'd256 : {1'b0, shift};
            fstate    <= F_DATA;
          end
          F_DATA: begin
            mem_wr_en   <= 1'b1;
            mem_wr_data <= shift;
            mem_wr_addr <= wr_ptr;
            wr_ptr      <= wr_ptr + 1'b1;
            sum         <= sum + shift;
            remaining   <= remaining - 9'd1;
            if (remaining == 9'd1) fstate <= F_CHK;
          end
          default: begin
            if (8'(sum + shift) == 8'd0) begin
              loaded    <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              error <= 1'b1;
            end
            busy   <= 1'b0;
            fstate <= F_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mem_wr_en_o   = mem_wr_en;
  assign bus.mem_wr_addr_o = mem_wr_addr;
  assign bus.mem_wr_data_o = mem_wr_data;
  assign bus.core_hold_o   = core_hold;
  assign bus.loaded_o      = loaded;
  assign bus.error_o       = error;
  assign bus.busy_o        = busy;
endmodule
`default_nettype wire

// File: tb/tb_lipsi_uart_loader.sv
`default_nettype none
// ============================================================================
// tb_lipsi_uart_loader : scoreboard bench driving framed UART images
// Revision: 1.0
// ============================================================================
module tb_lipsi_uart_loader;
  localparam int CPB = 8;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];
  logic prev_we = 1'b0;

  always #5 clock = ~clock;

  lipsi_uart_loader_if #(.ADDR_W(8)) bus ();

  lipsi_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (8),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard
  always @(negedge clock) begin
    if (bus.mem_wr_en_o === 1'b1) begin
      check("we_gap", 32'(prev_we), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.mem_wr_en_o), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_wr_addr_o), 32'(e.addr));
        check("wr_data", 32'(bus.mem_wr_data_o), 32'(e.data));
      end
    end
    prev_we <= bus.mem_wr_en_o;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx_i = bits[i];
      repeat (CPB) @(posedge clock);
    end
    bus.rx_i = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic status(input string tag, input logic hold, input logic ld,
                        input logic err, input logic bsy);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check({tag, "_core_hold"}, 32'(bus.core_hold_o), 32'(hold));
    check({tag, "_loaded"},    32'(bus.loaded_o),    32'(ld));
    check({tag, "_error"},     32'(bus.error_o),     32'(err));
    check({tag, "_busy"},      32'(bus.busy_o),      32'(bsy));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"},        32'(bus.mem_wr_en_o),   32'd0);
    check({tag, "_addr"},      32'(bus.mem_wr_addr_o), 32'd0);
    check({tag, "_data"},      32'(bus.mem_wr_data_o), 32'd0);
    check({tag, "_core_hold"}, 32'(bus.core_hold_o),   32'd1);
    check({tag, "_loaded"},    32'(bus.loaded_o),      32'd0);
    check({tag, "_error"},     32'(bus.error_o),       32'd0);
    check({tag, "_busy"},      32'(bus.busy_o),        32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    bus.rx_i = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check_reset_vals("rst");
    @(posedge clock);
    reset = 1'b0;
    repeat (50) @(posedge clock);
    status("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Good three-byte frame
    expect_wr(8'h00, 8'h11);
    expect_wr(8'h01, 8'h22);
    expect_wr(8'h02, 8'h33);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h9A);
    status("good", 1'b0, 1'b1, 1'b0, 1'b0);
    check("good_q_empty", 32'(exp_q.size()), 32'd0);

    // Bad checksum; the sync byte also exercises the reload path
    send_byte(8'hA5);
    status("reload", 1'b1, 1'b0, 1'b0, 1'b1);
    expect_wr(8'h00, 8'h10);
    expect_wr(8'h01, 8'h20);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h00);
    status("badchk", 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'hA5);
    status("errclr", 1'b1, 1'b0, 1'b0, 1'b1);
    expect_wr(8'h00, 8'h01);
    expect_wr(8'h01, 8'h02);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'hFD);
    status("recover", 1'b0, 1'b1, 1'b0, 1'b0);

    // Junk before a frame is ignored
    send_byte(8'h5A);
    send_byte(8'h00);
    send_byte(8'hFF);
    status("junk", 1'b0, 1'b1, 1'b0, 1'b0);
    expect_wr(8'h00, 8'h42);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'hBE);
    status("afterjunk", 1'b0, 1'b1, 1'b0, 1'b0);

    // Length 0 means 256 bytes; payload contains A5 as ordinary data
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      expect_wr(8'(i), 8'(i));
      send_byte(8'(i));
    end
    send_byte(8'h80);
    status("full", 1'b0, 1'b1, 1'b0, 1'b0);
    check("full_q_empty", 32'(exp_q.size()), 32'd0);

    // Framing error on a data byte
    expect_wr(8'h00, 8'h11);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    status("ferr", 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-frame
    expect_wr(8'h00, 8'h77);
    expect_wr(8'h01, 8'h88);
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h77);
    send_byte(8'h88);
    @(negedge clock);
    check("mid_busy", 32'(bus.busy_o), 32'd1);
    check("mid_addr", 32'(bus.mem_wr_addr_o), 32'd1);
    @(posedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (5) @(posedge clock);
    expect_wr(8'h00, 8'h42);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'hBE);
    status("postrst", 1'b0, 1'b1, 1'b0, 1'b0);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
